// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : 4-way round-robin arbiter with per-owner hold limit and enable.
// Revision : 1.0 - initial release
// ============================================================================

module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid
);

    localparam logic [3:0] C_MAX_HOLD = 4'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [1:0] idx_q,   idx_d;
    logic       valid_q, valid_d;
    logic [3:0] grant_q, grant_d;

    logic [1:0] w_base;
    logic [1:0] w_cand;
    logic [1:0] w_win;
    logic       w_found;
    logic       w_any;

    // In BUSY the only arbitration that matters is on release, which starts
    // just past the current owner; in IDLE it starts at the stored pointer.
    always_comb begin
        w_base = (state_q == ST_BUSY) ? (idx_q + 2'd1) : ptr_q;
    end

    always_comb begin
        w_win   = 2'd0;
        w_cand  = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_cand = w_base + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_any = |req;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (en && w_any) begin
                    state_d = ST_BUSY;
                    idx_d   = w_win;
                    cnt_d   = 4'd1;
                    valid_d = 1'b1;
                end else begin
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    valid_d = 1'b0;
                end
            end

            ST_BUSY: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + 2'd1;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    valid_d = 1'b0;
                end else if (req[idx_q] && (cnt_q < C_MAX_HOLD)) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    // Release; re-arbitrate on the same edge so there is no bubble.
                    ptr_d = idx_q + 2'd1;
                    if (w_any) begin
                        idx_d   = w_win;
                        cnt_d   = 4'd1;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 2'd0;
                        cnt_d   = 4'd0;
                        valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                cnt_d   = 4'd0;
                valid_d = 1'b0;
            end
        endcase

        grant_d = valid_d ? (4'b0001 << idx_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            grant_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4
// Purpose  : Self-checking bench for rr_arbiter4 against a round-robin model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_rr_arbiter4;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, for how long, and where search starts.
    bit m_busy;
    int m_owner;
    int m_cnt;
    int m_ptr;

    logic [3:0] exp_grant;
    logic [1:0] exp_idx;
    logic       exp_valid;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input int base, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    endfunction

    function automatic void model_edge(input logic e, input logic [3:0] r);
        if (!m_busy) begin
            if (e && r != 4'b0) begin
                m_owner = pick(m_ptr, r); m_busy = 1; m_cnt = 1;
            end
        end else if (!e) begin
            m_ptr = (m_owner + 1) % 4; m_busy = 0; m_cnt = 0;
        end else if (r[m_owner] && m_cnt < MAX_HOLD) begin
            m_cnt++;
        end else begin
            m_ptr = (m_owner + 1) % 4;
            if (r != 4'b0) begin
                m_owner = pick(m_ptr, r); m_cnt = 1;
            end else begin
                m_busy = 0; m_cnt = 0;
            end
        end
    endfunction

    function automatic void model_outputs();
        exp_valid = m_busy;
        exp_idx   = m_busy ? 2'(m_owner) : 2'd0;
        exp_grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    // One clock: model sees the same inputs the DUT sampled; returns 1ns later.
    task automatic cycle();
        @(posedge clk);
        model_edge(en, req);
        model_outputs();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; en = 1'b0; req = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (grant !== 4'b0000) begin
                n_fail++; $display("FAIL reset_grant: got %b want 0000", grant);
            end
            n_checks++;
            if (grant_idx !== 2'd0 || grant_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_idx_valid: got idx=%0d valid=%b want 0/0", grant_idx, grant_valid);
            end
        end
        reset_n = 1'b1; req = 4'b0000; en = 1'b0;
        model_reset();
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        do_reset();
        en = 1'b1; req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            cycle();
            want = 4'b0001 << ((c / 4) % 4);
            n_checks++;
            if (grant !== want || grant_valid !== 1'b1) begin
                n_fail++; $display("FAIL rotation c=%0d: got %b/%b want %b/1", c, grant, grant_valid, want);
            end
            n_checks++;
            if (grant_idx !== exp_idx) begin
                n_fail++; $display("FAIL rotation_idx c=%0d: got %0d want %0d", c, grant_idx, exp_idx);
            end
        end
    endtask

    task automatic test_pulse();
        do_reset();
        en = 1'b1; req = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            cycle();
            n_checks++;
            if (grant !== 4'b0100) begin
                n_fail++; $display("FAIL pulse_hold c=%0d: got %b want 0100", c, grant);
            end
        end
        req = 4'b0000;
        cycle();
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            n_fail++; $display("FAIL pulse_release: got %b/%b/%0d want 0000/0/0", grant, grant_valid, grant_idx);
        end
        // Pointer should now be 3, so requester 3 wins a full contest.
        req = 4'b1111;
        cycle();
        n_checks++;
        if (grant !== 4'b1000) begin
            n_fail++; $display("FAIL pulse_ptr3: got %b want 1000", grant);
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        en = 1'b1; req = 4'b0100;
        for (int c = 0; c < 13; c++) begin
            cycle();
            n_checks++;
            if (grant !== 4'b0100 || grant_valid !== 1'b1 || grant_idx !== 2'd2) begin
                n_fail++; $display("FAIL single_hold c=%0d: got %b/%b/%0d want 0100/1/2", c, grant, grant_valid, grant_idx);
            end
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        en = 1'b1; req = 4'b0010;
        cycle();
        cycle();
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++; $display("FAIL en_drop_owner: got %b want 0010", grant);
        end
        en = 1'b0;
        cycle();
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL en_drop_revoke: got %b/%b want 0000/0", grant, grant_valid);
        end
        cycle();
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL en_low_blocked: got %b want 0000", grant);
        end
        en = 1'b1; req = 4'b0011;
        cycle();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL en_rearm: got %b want 0001", grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; req = 4'b1000;
        cycle();
        n_checks++;
        if (grant !== 4'b1000) begin
            n_fail++; $display("FAIL async_pre: got %b want 1000", grant);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            n_fail++; $display("FAIL async_drop: got %b/%b/%0d want 0000/0/0", grant, grant_valid, grant_idx);
        end
        #1 reset_n = 1'b1;
        model_reset();
        req = 4'b1111;
        cycle();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++; $display("FAIL async_ptr0: got %b want 0001", grant);
        end
    endtask

    task automatic test_random();
        logic [3:0] prev;
        int run;
        do_reset();
        prev = 4'b0000; run = 0;
        for (int c = 0; c < 10000; c++) begin
            req = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 9) != 0);
            cycle();
            n_checks++;
            if (grant !== exp_grant || grant_idx !== exp_idx || grant_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL random_model c=%0d req=%b en=%b: got %b/%0d/%b want %b/%0d/%b",
                         c, req, en, grant, grant_idx, grant_valid, exp_grant, exp_idx, exp_valid);
            end
            n_checks++;
            if ((grant & (grant - 4'd1)) !== 4'b0000 || grant_valid !== (|grant)) begin
                n_fail++; $display("FAIL random_onehot c=%0d: got %b valid=%b want onehot0", c, grant, grant_valid);
            end
            n_checks++;
            if ((grant & ~req) !== 4'b0000) begin
                n_fail++; $display("FAIL random_backed c=%0d: got grant %b req %b want grant within req", c, grant, req);
            end
            // Past MAX_HOLD a repeat is legal only as the lone-requester wrap.
            if (grant != 4'b0000 && grant == prev) begin
                if (run == MAX_HOLD) begin
                    n_checks++;
                    if ((req & ~grant) !== 4'b0000) begin
                        n_fail++; $display("FAIL random_maxhold c=%0d: got run>%0d with req %b want rotate", c, MAX_HOLD, req);
                    end
                    run = 1;
                end else begin
                    run++;
                end
            end else begin
                run = (grant != 4'b0000) ? 1 : 0;
            end
            prev = grant;
        end
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; req = 4'b0000;
        model_reset();
        test_reset();
        test_rotation();
        test_pulse();
        test_single_hold();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 4, giving the maximum consecutive grant cycles per owner (legal range 1..15).
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port en  input  1  arbiter enable; low blocks and revokes grants.
REQ-005 SHALL provide port req  input  4  request vector, bit i = requester i, level-sensitive.
REQ-006 SHALL provide port grant  output  4  registered grant, one-hot or all-zero.
REQ-007 SHALL provide port grant_idx  output  2  binary index of the owner; 0 when grant_valid is low.
REQ-008 SHALL provide port grant_valid  output  1  high when grant is non-zero.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner = grant_idx).
REQ-010 SHALL hold a priority pointer ptr[1:0] and a hold counter cnt[3:0].
REQ-011 SHALL search requesters in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set req bit wins.
REQ-012 SHALL register all outputs: a request sampled at edge N is reflected on grant after edge N (latency 1 cycle).
REQ-013 SHALL, in IDLE with en=1 and req!=0, grant the winner, enter BUSY, and set cnt=1.
REQ-014 SHALL, in IDLE with en=0 or req=0, remain in IDLE with grant=0 and ptr unchanged.
REQ-015 SHALL, in BUSY with en=1, req[owner]=1 and cnt<MAX_HOLD, keep the same grant and increment cnt.
REQ-016 SHALL release the owner in BUSY when req[owner]=0 or cnt=MAX_HOLD, and set ptr=owner+1 (mod 4) on that edge.
REQ-017 SHALL, on release with en=1, arbitrate on the same edge using the updated ptr, granting the new winner with cnt=1 and no idle bubble.
REQ-018 SHALL enter IDLE with grant=0 when release arbitration finds req=0.
REQ-019 SHALL let the released owner win again at cnt=1 only when no other request is set (the wrap-around case).
REQ-020 SHALL, when en=0 in BUSY, drive grant to 0 on the next edge, enter IDLE, and set ptr=owner+1 (mod 4).
REQ-021 SHALL have no grant re-arm until the cycle after en returns high.
REQ-022 SHALL treat simultaneous req drop and hold expiry as a single release (REQ-016).
REQ-023 SHALL assert grant only for a requester whose req bit was high at the sampling edge.
REQ-024 SHALL keep grant_valid equal to the OR of grant and grant_idx consistent with grant every cycle.
REQ-025 SHALL constrain cnt arithmetic to 4 bits and never let it exceed MAX_HOLD.

Reset
REQ-026 SHALL, on reset_n low, immediately and asynchronously force state=IDLE, ptr=0, cnt=0, grant=0, grant_idx=0, grant_valid=0.
REQ-027 SHALL, on reset_n asserted mid-grant, drop grant with no wait for a clock edge.
REQ-028 SHALL make the first arbitration after reset_n deasserts use ptr=0.
REQ-029 SHALL hold all outputs at reset values while reset_n is low, regardless of req and en.

Verification
REQ-030 SHALL cover: reset, en=1, req=4'b1111 -> grant=0001 for 4 cycles, then 0010, 0100, 1000, 0001, each held 4 cycles with no bubble.
REQ-031 SHALL cover: req=4'b0100 pulsed for 2 cycles then 0 -> grant=0100 for 2 cycles, then grant=0, IDLE, ptr=3.
REQ-032 SHALL cover: MAX_HOLD=4, only req[2] held high -> grant=0100 continuously, with cnt wrapping 1..4 and grant_valid never low.
REQ-033 SHALL cover: owner 1 busy at cnt=2, en driven low -> grant=0 on the next edge; with en high again and req=0011 -> grant=0001.
REQ-034 SHALL cover: reset_n pulsed low between edges while grant=1000 -> grant=0 without a clock edge; the first grant afterwards follows ptr=0.
REQ-035 SHALL cover: random req/en for 10k cycles -> grant is always one-hot or zero, each grant is backed by req, and no owner exceeds MAX_HOLD consecutive cycles.
